// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron training path.
package perceptron_pkg;

    localparam int unsigned N_INPUTS_DEF = 4;
    localparam int unsigned SIGN_DEF     = 1;
    localparam int unsigned Q_M_DEF      = 16;
    localparam int unsigned Q_N_DEF      = 16;
    localparam int unsigned LR_SHIFT_DEF = 4;

    function automatic int unsigned calc_w(input int unsigned sign_bits,
                                           input int unsigned q_m,
                                           input int unsigned q_n);
        return sign_bits + q_m + q_n;
    endfunction

    localparam int unsigned W_DEF = calc_w(SIGN_DEF, Q_M_DEF, Q_N_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_BIAS,
        ST_DONE
    } state_e;

    typedef logic signed [W_DEF-1:0] fixed_t;

    localparam fixed_t FIXED_ONE = fixed_t'(1) << Q_N_DEF;

endpackage

// File: rtl/fixed_sat_addsub.sv
// Signed fixed-point add/subtract with clamping to the W-bit two's complement range.
module fixed_sat_addsub
    import perceptron_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  logic                sub_i,
    output logic signed [W-1:0] sum_c_o
);

    localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] a_ext;
    logic signed [W:0] b_ext;
    logic signed [W:0] raw;

    assign a_ext = {a_i[W-1], a_i};
    assign b_ext = {b_i[W-1], b_i};
    assign raw   = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);

    // Top two bits disagree only when the true result left the W-bit range.
    always_comb begin
        sum_c_o = raw[W-1:0];
        if (raw[W] != raw[W-1]) begin
            sum_c_o = raw[W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/perceptron_weight_update.sv
// Perceptron learning-rule engine: owns weights/bias and updates them serially.
// Optional direct weight loading in IDLE is enabled by PERCEPTRON_WEIGHT_LOAD_EN.
module perceptron_weight_update
    import perceptron_pkg::*;
#(
    parameter int unsigned N_INPUTS = N_INPUTS_DEF,
    parameter int unsigned SIGN     = SIGN_DEF,
    parameter int unsigned Q_M      = Q_M_DEF,
    parameter int unsigned Q_N      = Q_N_DEF,
    parameter int unsigned LR_SHIFT = LR_SHIFT_DEF,
    localparam int unsigned W       = calc_w(SIGN, Q_M, Q_N)
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
   ,localparam int unsigned LD_W    = $clog2(N_INPUTS + 1)
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  target_i,
    input  logic                  activation_i,
    input  logic [N_INPUTS*W-1:0] x_i,
    output logic [N_INPUTS*W-1:0] weights_o,
    output logic [W-1:0]          bias_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           err_count_o
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
   ,input  logic                  load_i,
    input  logic [LD_W-1:0]       load_idx_i,
    input  logic [W-1:0]          load_data_i
`endif
);

    localparam int unsigned IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic signed [W-1:0] BIAS_STEP = W'(1) << (Q_N - LR_SHIFT);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  sub_q, sub_d;
    logic signed [W-1:0]   x_q [N_INPUTS];
    logic signed [W-1:0]   x_d [N_INPUTS];
    logic signed [W-1:0]   w_q [N_INPUTS];
    logic signed [W-1:0]   w_d [N_INPUTS];
    logic signed [W-1:0]   bias_q, bias_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic signed [W-1:0]   op_a;
    logic signed [W-1:0]   op_b;
    logic signed [W-1:0]   sum_c;

    // One shared saturating adder serves both the weight and bias steps.
    always_comb begin
        op_a = bias_q;
        op_b = BIAS_STEP;
        if (state_q == ST_UPDATE) begin
            for (int k = 0; k < N_INPUTS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    op_a = w_q[k];
                    op_b = x_q[k] >>> LR_SHIFT;
                end
            end
        end
    end

    fixed_sat_addsub #(
        .W (W)
    ) u_addsub (
        .a_i     (op_a),
        .b_i     (op_b),
        .sub_i   (sub_q),
        .sum_c_o (sum_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sub_q     <= 1'b0;
            bias_q    <= '0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int k = 0; k < N_INPUTS; k++) begin
                w_q[k] <= '0;
                x_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sub_q     <= sub_d;
            bias_q    <= bias_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int k = 0; k < N_INPUTS; k++) begin
                w_q[k] <= w_d[k];
                x_q[k] <= x_d[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sub_d     = sub_q;
        bias_d    = bias_q;
        err_cnt_d = err_cnt_q;
        for (int k = 0; k < N_INPUTS; k++) begin
            w_d[k] = w_q[k];
            x_d[k] = x_q[k];
        end

        case (state_q)
            ST_IDLE: begin
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
                if (load_i) begin
                    // Index N_INPUTS addresses the bias.
                    if (load_idx_i == LD_W'(N_INPUTS)) begin
                        bias_d = load_data_i;
                    end
                    for (int k = 0; k < N_INPUTS; k++) begin
                        if (load_idx_i == LD_W'(k)) begin
                            w_d[k] = load_data_i;
                        end
                    end
                end else
`endif
                if (start_i) begin
                    for (int k = 0; k < N_INPUTS; k++) begin
                        x_d[k] = x_i[k*W +: W];
                    end
                    if (target_i == activation_i) begin
                        state_d = ST_DONE;
                    end else begin
                        // err = -1 exactly when the activation fired wrongly.
                        sub_d = activation_i;
                        idx_d = '0;
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        state_d = ST_UPDATE;
                    end
                end
            end

            ST_UPDATE: begin
                for (int k = 0; k < N_INPUTS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        w_d[k] = sum_c;
                    end
                end
                if (idx_q == IDX_W'(N_INPUTS - 1)) begin
                    state_d = ST_BIAS;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_BIAS: begin
                bias_d  = sum_c;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_wout
        assign weights_o[g*W +: W] = w_q[g];
    end

    assign bias_o      = bias_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_perceptron_weight_update.sv
// Directed bench for perceptron_weight_update with hand-computed expectations.
module tb_perceptron_weight_update;
    import perceptron_pkg::*;

    localparam int unsigned N  = N_INPUTS_DEF;
    localparam int unsigned W  = calc_w(SIGN_DEF, Q_M_DEF, Q_N_DEF);
    localparam int unsigned NW = N * W;

    localparam fixed_t X1   = FIXED_ONE;
    localparam fixed_t X2   = 33'h0_0002_0000;
    localparam fixed_t X3   = 33'h0_0003_0000;
    localparam fixed_t X4   = 33'h0_0004_0000;
    localparam fixed_t XM1  = -FIXED_ONE;
    localparam fixed_t MAXV = 33'h0_FFFF_FFFF;
    localparam fixed_t MINV = 33'h1_0000_0000;
    localparam fixed_t ZERO = 33'h0;

    logic          clk;
    logic          rst;
    logic          start;
    logic          target;
    logic          activation;
    logic [NW-1:0] x;
    logic [NW-1:0] weights;
    logic [W-1:0]  bias;
    logic          busy;
    logic          done;
    logic [15:0]   err_count;
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
    localparam int unsigned LD_W = $clog2(N + 1);
    logic            load;
    logic [LD_W-1:0] load_idx;
    logic [W-1:0]    load_data;
`endif

    int            n_pass;
    int            n_total;
    logic [NW-1:0] w_snap;

    perceptron_weight_update dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .target_i     (target),
        .activation_i (activation),
        .x_i          (x),
        .weights_o    (weights),
        .bias_o       (bias),
        .busy_o       (busy),
        .done_o       (done),
        .err_count_o  (err_count)
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
       ,.load_i       (load),
        .load_idx_i   (load_idx),
        .load_data_i  (load_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] wk(input int k);
        return weights[k*W +: W];
    endfunction

    function automatic logic [NW-1:0] pack4(input fixed_t e0, input fixed_t e1,
                                            input fixed_t e2, input fixed_t e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; start is seen by the next posedge.
    task automatic do_step(input string tag, input logic t, input logic a,
                           input logic [NW-1:0] xv, input int exp_lat);
        int lat;
        start      = 1'b1;
        target     = t;
        activation = a;
        x          = xv;
        @(negedge clk);
        start      = 1'b0;
        x          = '0;
        target     = ~t;
        activation = ~a;
        check({tag, "_busy"}, W'(busy), W'(1));
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 2) w_snap = weights;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, W'(lat), W'(exp_lat));
        @(negedge clk);
        check({tag, "_done_fall"}, W'(done), W'(0));
        check({tag, "_idle"}, W'(busy), W'(0));
    endtask

    initial begin
        int n_done;
        int first;
        n_pass     = 0;
        n_total    = 0;
        start      = 1'b0;
        target     = 1'b0;
        activation = 1'b0;
        x          = '0;
`ifdef PERCEPTRON_WEIGHT_LOAD_EN
        load       = 1'b0;
        load_idx   = '0;
        load_data  = '0;
`endif
        do_reset(2);
        @(negedge clk);
        check("rst_bias", bias, W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_err", W'(err_count), W'(0));
        for (int k = 0; k < N; k++) check("rst_w", wk(k), W'(0));

        // Positive update: err = +1
        do_step("pos", 1'b1, 1'b0, pack4(X1, X2, XM1, ZERO), 6);
        check("pos_mid_w0", w_snap[0 +: W], 33'h0_0000_1000);
        check("pos_mid_w1", w_snap[W +: W], 33'h0);
        check("pos_w0", wk(0), 33'h0_0000_1000);
        check("pos_w1", wk(1), 33'h0_0000_2000);
        check("pos_w2", wk(2), 33'h1_FFFF_F000);
        check("pos_w3", wk(3), 33'h0);
        check("pos_bias", bias, 33'h0_0000_1000);
        check("pos_err", W'(err_count), W'(1));

        // Negative update undoes it
        do_step("neg", 1'b0, 1'b1, pack4(X1, X2, XM1, ZERO), 6);
        for (int k = 0; k < N; k++) check("neg_w", wk(k), W'(0));
        check("neg_bias", bias, W'(0));
        check("neg_err", W'(err_count), W'(2));

        // No-op: err = 0
        do_step("nop", 1'b1, 1'b1, pack4(X1, X2, XM1, ZERO), 1);
        for (int k = 0; k < N; k++) check("nop_w", wk(k), W'(0));
        check("nop_bias", bias, W'(0));
        check("nop_err", W'(err_count), W'(2));

        // start and x changes during UPDATE are ignored
        start = 1'b1; target = 1'b1; activation = 1'b0;
        x = pack4(X1, X2, X3, X4);
        @(negedge clk);
        target = 1'b0; activation = 1'b1;
        x = pack4(MINV, MINV, MINV, MINV);
        n_done = 0;
        first  = 0;
        for (int i = 1; i <= 12; i++) begin
            if (done) begin
                n_done++;
                if (first == 0) first = i;
            end
            if (i == 3) start = 1'b0;
            @(negedge clk);
        end
        check("busy_start_ndone", W'(n_done), W'(1));
        check("busy_start_lat", W'(first), W'(6));
        check("busy_start_w0", wk(0), 33'h0_0000_1000);
        check("busy_start_w1", wk(1), 33'h0_0000_2000);
        check("busy_start_w2", wk(2), 33'h0_0000_3000);
        check("busy_start_w3", wk(3), 33'h0_0000_4000);
        check("busy_start_bias", bias, 33'h0_0000_1000);
        check("busy_start_err", W'(err_count), W'(3));
        check("busy_start_idle", W'(busy), W'(0));

        // Reset while UPDATE is at idx 2
        start = 1'b1; target = 1'b1; activation = 1'b0;
        x = pack4(X1, X2, X3, X4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_mid_w0", wk(0), 33'h0_0000_2000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_bias", bias, W'(0));
        check("abort_err", W'(err_count), W'(0));
        for (int k = 0; k < N; k++) check("abort_w", wk(k), W'(0));
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", W'(n_done), W'(0));
        check("abort_idle", W'(busy), W'(0));

        // Saturation while adding: w0 climbs to max, w1 falls to min
        for (int s = 0; s < 16; s++) do_step("satA", 1'b1, 1'b0, pack4(MAXV, MINV, ZERO, ZERO), 6);
        check("satA16_w0", wk(0), 33'h0_FFFF_FFF0);
        check("satA16_w1", wk(1), 33'h1_0000_0000);
        do_step("satA", 1'b1, 1'b0, pack4(MAXV, MINV, ZERO, ZERO), 6);
        check("satA17_w0", wk(0), 33'h0_FFFF_FFFF);
        check("satA17_w1", wk(1), 33'h1_0000_0000);
        check("satA17_bias", bias, 33'h0_0001_1000);
        check("satA17_err", W'(err_count), W'(17));

        // Saturation while subtracting
        do_reset(1);
        for (int s = 0; s < 15; s++) do_step("satB", 1'b0, 1'b1, pack4(MINV, MAXV, ZERO, ZERO), 6);
        check("satB15_w0", wk(0), 33'h0_F000_0000);
        check("satB15_w1", wk(1), 33'h1_1000_000F);
        do_step("satB", 1'b0, 1'b1, pack4(MINV, MAXV, ZERO, ZERO), 6);
        check("satB16_w0", wk(0), 33'h0_FFFF_FFFF);
        check("satB16_w1", wk(1), 33'h1_0000_0010);
        do_step("satB", 1'b0, 1'b1, pack4(MINV, MAXV, ZERO, ZERO), 6);
        check("satB17_w0", wk(0), 33'h0_FFFF_FFFF);
        check("satB17_w1", wk(1), 33'h1_0000_0000);
        check("satB17_bias", bias, 33'h1_FFFE_F000);
        check("satB17_err", W'(err_count), W'(17));

`ifdef PERCEPTRON_WEIGHT_LOAD_EN
        do_reset(1);
        load = 1'b1; load_idx = LD_W'(0); load_data = 33'h0_FFFF_F000;
        @(negedge clk);
        load = 1'b0;
        check("ld_w0", wk(0), 33'h0_FFFF_F000);
        do_step("ldsat1", 1'b1, 1'b0, pack4(X1, ZERO, ZERO, ZERO), 6);
        check("ldsat1_w0", wk(0), 33'h0_FFFF_FFFF);
        do_step("ldsat2", 1'b1, 1'b0, pack4(X1, ZERO, ZERO, ZERO), 6);
        check("ldsat2_w0", wk(0), 33'h0_FFFF_FFFF);
        load = 1'b1; load_idx = LD_W'(1); load_data = 33'h1_0000_0000;
        @(negedge clk);
        load = 1'b0;
        do_step("ldmin", 1'b0, 1'b1, pack4(ZERO, X1, ZERO, ZERO), 6);
        check("ldmin_w1", wk(1), 33'h1_0000_0000);
        check("ldmin_w0", wk(0), 33'h0_FFFF_FFFF);
        load = 1'b1; load_idx = LD_W'(N); load_data = 33'h0_0000_0005;
        @(negedge clk);
        load = 1'b0;
        check("ld_bias", bias, 33'h0_0000_0005);
        load = 1'b1; load_idx = LD_W'(3); load_data = 33'h0_0000_0007;
        start = 1'b1; target = 1'b1; activation = 1'b0; x = pack4(X1, X1, X1, X1);
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check("ldwin_busy", W'(busy), W'(0));
        check("ldwin_w3", wk(3), 33'h0_0000_0007);
        check("ldwin_err", W'(err_count), W'(3));
        start = 1'b1; target = 1'b1; activation = 1'b0; x = '0;
        @(negedge clk);
        start = 1'b0;
        load = 1'b1; load_idx = LD_W'(0); load_data = 33'h0;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        check("ldbusy_w0", wk(0), 33'h0_FFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/perceptron_weight_update.md
Name: perceptron_weight_update

Overview:
- Backward (training) path of the perceptron. It consumes the 1-bit output of the step activation and a 1-bit target, then applies the perceptron learning rule to every weight and the bias.
- Weights and bias are signed fixed-point with the same format as the forward-path summation: sign+q_m+q_n bits, two's complement.
- The block owns the weight/bias registers and exposes them to the forward-path multiply-accumulate.
- Updates are serial: one weight per cycle, controlled by an FSM.

Parameters:
- N_INPUTS, 4, number of perceptron inputs/weights.
- sign, 1, sign bit count of the fixed-point format.
- q_m, 16, integer bits.
- q_n, 16, fractional bits.
- LR_SHIFT, 4, learning rate = 2^-LR_SHIFT, applied as an arithmetic right shift.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request one training step; sampled only in IDLE.
- target_i  in  1  desired output.
- activation_i  in  1  forward-path activation for the same sample.
- x_i  in  N_INPUTS*W  packed sample inputs, W = sign+q_m+q_n; element k is at [k*W +: W].
- weights_o  out  N_INPUTS*W  packed current weights.
- bias_o  out  W  current bias.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse when a step completes.
- err_count_o  out  16  count of steps with nonzero error; saturates at 0xFFFF.

Behaviour:
- Reset (synchronous, active-high): all weights=0, bias=0, err_count_o=0, busy_o=0, done_o=0, state=IDLE. Reset asserted in any state aborts the step and clears the weights on the same edge.
- States are IDLE, UPDATE, BIAS, DONE.
- IDLE, on an edge with start_i=1:
  - Latch target_i, activation_i and x_i into internal registers.
  - Compute err = target - activation, with err ∈ {-1, 0, +1}.
  - If err=0, go to DONE.
  - Otherwise set idx=0, increment err_count_o (saturating), and go to UPDATE.
- UPDATE: each cycle, w[idx] <= sat(w[idx] ± (x_lat[idx] >>> LR_SHIFT)).
  - Add when err=+1, subtract when err=-1.
  - The shift is arithmetic (sign-preserving) and truncates.
  - When idx=N_INPUTS-1, go to BIAS; otherwise increment idx.
- BIAS: bias <= sat(bias ± (1 << (q_n-LR_SHIFT))), then go to DONE.
- DONE: done_o=1 for exactly this cycle, then go to IDLE.
- Latency, with start sampled at edge t:
  - err≠0: done_o is high in the cycle after edge t+N_INPUTS+1.
  - err=0: done_o is high in the cycle after edge t.
  - busy_o is high from edge t until done_o falls.
- start_i while busy_o=1 is ignored. It is not queued.
- x_i, target_i and activation_i may change after the start edge without effect.
- Saturation: the add/sub is computed in W+1 bits.
  - Results above 2^(W-1)-1 clamp to 0x0_FFFF_FFFF (default W=33).
  - Results below -2^(W-1) clamp to 0x1_0000_0000.
- weights_o and bias_o are registered and change only on update edges. A weight's new value is visible in the cycle after its UPDATE edge.

Optional Feature:
- Macro: PERCEPTRON_WEIGHT_LOAD_EN.
- When defined, three extra ports exist:
  - load_i  in  1.
  - load_idx_i  in  $clog2(N_INPUTS+1).
  - load_data_i  in  W.
- In IDLE, load_i=1 writes load_data_i to w[load_idx_i] on that edge; load_idx_i=N_INPUTS writes the bias instead.
- If load_i and start_i are both asserted, load wins and start is ignored.
- load_i is ignored outside IDLE.
- When the macro is undefined, these ports are absent and weights initialise only through reset.

Decomposition:
- Shared package perceptron_pkg holds:
  - localparam function for W.
  - typedef enum for the FSM states.
  - typedef for the fixed-point word.
  - constant FIXED_ONE = 1<<q_n.
- One sub-module: fixed_sat_addsub. It is combinational, parameterised on W, and provides signed add/sub with saturation. It is used for both the weight update and the bias update.

Test Plan (defaults, W=33, 1.0=0x10000, N_INPUTS=4):
- Reset: assert rst_i for 2 cycles mid-run -> weights_o=0, bias_o=0, busy_o=0, done_o=0, err_count_o=0.
- Positive update: target=1, activation=0, x={1.0, 2.0, -1.0, 0} -> done_o 6 cycles after the start edge; w={0x1000, 0x2000, 0x1_FFFF_F000, 0}; bias=0x1000; err_count_o=1.
- Negative update, then no-op:
  - Repeat the positive-update sample with target=0, activation=1 -> all weights and bias return to 0; err_count_o=2.
  - Then target=activation=1 -> done_o on the cycle after the start edge, nothing changes, err_count_o stays 2.
- start_i asserted during UPDATE, and x_i changed during UPDATE -> ignored. Exactly one done_o pulse; results use the latched x.
- PERCEPTRON_WEIGHT_LOAD_EN saturation:
  - Load w0=0x0_FFFF_F000, then train with x0=1.0, err=+1 -> w0=0x0_FFFF_FFFF exactly.
  - A second identical step -> stays 0x0_FFFF_FFFF.
  - Load w1=0x1_0000_0000 with x1=1.0, err=-1 -> stays at the minimum.
- Reset asserted at UPDATE idx=2 -> on the next cycle state=IDLE, weights=0, no done_o pulse.
